// File: rtl/matmul_self_check_pkg.sv
// Shared definitions for the matrix-multiply self-checker: FSM state
// encoding, data-memory base addresses and a constant clog2 helper.
package matmul_self_check_pkg;

    // state  | meaning
    // IDLE   | counting towards timeout, waiting for done rising edge
    // ADDR_A | read matrix1[i][k]
    // ADDR_B | capture a, read matrix2[k][j]
    // ACC    | acc += a * matrix2[k][j]
    // ADDR_C | read result[i][j]
    // CMP    | compare result against acc, advance i/j
    // FINISH | results published; left only through reset
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ADDR_A = 3'd1,
        ADDR_B = 3'd2,
        ACC    = 3'd3,
        ADDR_C = 3'd4,
        CMP    = 3'd5,
        FINISH = 3'd6
    } state_t;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            r = r + 1;
        end
        return r;
    endfunction

    function automatic int base_a();
        return 0;
    endfunction

    function automatic int base_b(input int m, input int n);
        return m * n;
    endfunction

    function automatic int base_c(input int m, input int n, input int n2);
        return m * n + n * n2;
    endfunction

endpackage

// File: rtl/matmul_self_check_mac.sv
// DW-bit multiply-accumulate with synchronous clear and enable.
// Ports: clk_sys/rst_n clock and async active-low reset; clr zeroes the
// accumulator (wins over en); en adds a*b; acc is the registered sum.
// The product is kept to DW bits: the low DW bits of a two's-complement
// product are identical for signed and unsigned operands, so the result
// matches modulo-2^DW CPU arithmetic without a sign-extended multiplier.
module matmul_mac #(
    parameter int DW = 32
) (
    input  logic          clk_sys,
    input  logic          rst_n,
    input  logic          clr,
    input  logic          en,
    input  logic [DW-1:0] a,
    input  logic [DW-1:0] b,
    output logic [DW-1:0] acc
);

    logic [DW-1:0] acc_q;
    logic [DW-1:0] acc_d;
    logic [DW-1:0] prod;

    always_comb begin
        prod  = a * b;
        acc_d = acc_q;
        if (clr) begin
            acc_d = '0;
        end else if (en) begin
            acc_d = acc_q + prod;
        end
    end

    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign acc = acc_q;

endmodule

// File: rtl/matmul_self_check.sv
// On-chip checker for the RISCVCPU matrix-multiply program. Waits for the
// done rising edge (or a cycle timeout), latches the CPU counters, then
// re-reads matrix1/matrix2/result from data memory, recomputes every
// element with a MAC and reports pass/fail, mismatch count and first bad
// element.
// Ports: CLOCK_50/rst_n clock and async active-low reset; done,
// clock_count, instr_cnt from the CPU; mem_rd_en/mem_addr/mem_rd_data
// data-memory read port (1-cycle latency); busy, check_done, pass,
// timeout, no_instr, mismatch_cnt, first_bad_row/col, cycles_latched and
// instr_latched are the results.
module matmul_self_check
    import matmul_self_check_pkg::*;
#(
    parameter int M       = 2,
    parameter int N       = 4,
    parameter int N2      = 2,
    parameter int DW      = 32,
    parameter int TIMEOUT = 5000,
    parameter int AW      = clog2(M*N + N*N2 + M*N2)
) (
    input  logic                CLOCK_50,
    input  logic                rst_n,
    input  logic                done,
    input  logic [15:0]         clock_count,
    input  logic [15:0]         instr_cnt,
    output logic                mem_rd_en,
    output logic [AW-1:0]       mem_addr,
    input  logic [DW-1:0]       mem_rd_data,
    output logic                busy,
    output logic                check_done,
    output logic                pass,
    output logic                timeout,
    output logic                no_instr,
    output logic [15:0]         mismatch_cnt,
    output logic [clog2(M):0]   first_bad_row,
    output logic [clog2(N2):0]  first_bad_col,
    output logic [15:0]         cycles_latched,
    output logic [15:0]         instr_latched
);

    localparam int RW = clog2(M) + 1;
    localparam int CW = clog2(N2) + 1;
    localparam int KW = clog2(N) + 1;
    localparam int TW = clog2(TIMEOUT) + 1;

    state_t          state_q, state_d;
    logic            done_q;
    logic [TW-1:0]   tmo_cnt_q, tmo_cnt_d;
    logic [RW-1:0]   i_q, i_d;
    logic [CW-1:0]   j_q, j_d;
    logic [KW-1:0]   k_q, k_d;
    logic [DW-1:0]   a_q, a_d;
    logic [15:0]     mismatch_cnt_q, mismatch_cnt_d;
    logic [RW-1:0]   first_bad_row_q, first_bad_row_d;
    logic [CW-1:0]   first_bad_col_q, first_bad_col_d;
    logic [15:0]     cycles_latched_q, cycles_latched_d;
    logic [15:0]     instr_latched_q, instr_latched_d;
    logic            timeout_q, timeout_d;
    logic            no_instr_q, no_instr_d;
    logic            res_valid_q, res_valid_d;
    logic            check_done_q, check_done_d;
    logic            pass_q, pass_d;
    logic            done_rise;
    logic            mac_clr;
    logic            mac_en;
    logic [DW-1:0]   mac_acc;

    matmul_mac #(.DW(DW)) u_mac (
        .clk_sys (CLOCK_50),
        .rst_n   (rst_n),
        .clr     (mac_clr),
        .en      (mac_en),
        .a       (a_q),
        .b       (mem_rd_data),
        .acc     (mac_acc)
    );

    always_comb begin
        state_d          = state_q;
        tmo_cnt_d        = tmo_cnt_q;
        i_d              = i_q;
        j_d              = j_q;
        k_d              = k_q;
        a_d              = a_q;
        mismatch_cnt_d   = mismatch_cnt_q;
        first_bad_row_d  = first_bad_row_q;
        first_bad_col_d  = first_bad_col_q;
        cycles_latched_d = cycles_latched_q;
        instr_latched_d  = instr_latched_q;
        timeout_d        = timeout_q;
        no_instr_d       = no_instr_q;
        mem_rd_en        = 1'b0;
        mem_addr         = '0;
        mac_clr          = 1'b0;
        mac_en           = 1'b0;
        done_rise        = done && !done_q;

        case (state_q)
            IDLE: begin
                tmo_cnt_d = tmo_cnt_q + TW'(1);
                // A done edge in the expiry cycle wins, so timeout stays clear.
                if (done_rise || tmo_cnt_q == TW'(TIMEOUT - 1)) begin
                    cycles_latched_d = clock_count;
                    instr_latched_d  = instr_cnt;
                    no_instr_d       = (instr_cnt == 16'd0);
                    timeout_d        = !done_rise;
                    i_d              = '0;
                    j_d              = '0;
                    k_d              = '0;
                    mac_clr          = 1'b1;
                    state_d          = ADDR_A;
                end
            end
            ADDR_A: begin
                mem_rd_en = 1'b1;
                mem_addr  = AW'(base_a() + int'(i_q) * N + int'(k_q));
                state_d   = ADDR_B;
            end
            ADDR_B: begin
                a_d       = mem_rd_data;
                mem_rd_en = 1'b1;
                mem_addr  = AW'(base_b(M, N) + int'(k_q) * N2 + int'(j_q));
                state_d   = ACC;
            end
            ACC: begin
                mac_en = 1'b1;
                if (k_q == KW'(N - 1)) begin
                    k_d     = '0;
                    state_d = ADDR_C;
                end else begin
                    k_d     = k_q + KW'(1);
                    state_d = ADDR_A;
                end
            end
            ADDR_C: begin
                mem_rd_en = 1'b1;
                mem_addr  = AW'(base_c(M, N, N2) + int'(i_q) * N2 + int'(j_q));
                state_d   = CMP;
            end
            CMP: begin
                if (mem_rd_data != mac_acc) begin
                    // The count never wraps, so zero still means "no mismatch yet".
                    if (mismatch_cnt_q == 16'd0) begin
                        first_bad_row_d = i_q;
                        first_bad_col_d = j_q;
                    end
                    if (mismatch_cnt_q != 16'hFFFF) begin
                        mismatch_cnt_d = mismatch_cnt_q + 16'd1;
                    end
                end
                mac_clr = 1'b1;
                if (j_q == CW'(N2 - 1)) begin
                    j_d = '0;
                    i_d = i_q + RW'(1);
                end else begin
                    j_d = j_q + CW'(1);
                end
                if (i_q == RW'(M - 1) && j_q == CW'(N2 - 1)) begin
                    state_d = FINISH;
                end else begin
                    state_d = ADDR_A;
                end
            end
            FINISH: begin
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // FINISH -> res_valid -> check_done/pass: results are published from
        // settled registered counts, two edges after the last compare.
        res_valid_d  = (state_q == FINISH);
        check_done_d = res_valid_q;
        pass_d       = res_valid_q && (mismatch_cnt_q == 16'd0) && !timeout_q;
    end

    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) begin
            state_q          <= IDLE;
            done_q           <= 1'b0;
            tmo_cnt_q        <= '0;
            i_q              <= '0;
            j_q              <= '0;
            k_q              <= '0;
            a_q              <= '0;
            mismatch_cnt_q   <= '0;
            first_bad_row_q  <= '0;
            first_bad_col_q  <= '0;
            cycles_latched_q <= '0;
            instr_latched_q  <= '0;
            timeout_q        <= 1'b0;
            no_instr_q       <= 1'b0;
            res_valid_q      <= 1'b0;
            check_done_q     <= 1'b0;
            pass_q           <= 1'b0;
        end else begin
            state_q          <= state_d;
            done_q           <= done;
            tmo_cnt_q        <= tmo_cnt_d;
            i_q              <= i_d;
            j_q              <= j_d;
            k_q              <= k_d;
            a_q              <= a_d;
            mismatch_cnt_q   <= mismatch_cnt_d;
            first_bad_row_q  <= first_bad_row_d;
            first_bad_col_q  <= first_bad_col_d;
            cycles_latched_q <= cycles_latched_d;
            instr_latched_q  <= instr_latched_d;
            timeout_q        <= timeout_d;
            no_instr_q       <= no_instr_d;
            res_valid_q      <= res_valid_d;
            check_done_q     <= check_done_d;
            pass_q           <= pass_d;
        end
    end

    assign busy           = (state_q != IDLE) && (state_q != FINISH);
    assign check_done     = check_done_q;
    assign pass           = pass_q;
    assign timeout        = timeout_q;
    assign no_instr       = no_instr_q;
    assign mismatch_cnt   = mismatch_cnt_q;
    assign first_bad_row  = first_bad_row_q;
    assign first_bad_col  = first_bad_col_q;
    assign cycles_latched = cycles_latched_q;
    assign instr_latched  = instr_latched_q;

endmodule

// File: tb/tb_matmul_self_check.sv
module tb_matmul_self_check;

    localparam int M  = 2;
    localparam int N  = 4;
    localparam int N2 = 2;
    localparam int DW = 32;
    localparam int AW = 5;
    localparam int BB = M * N;
    localparam int BC = M * N + N * N2;
    localparam int LAT = M * N2 * (3 * N + 2) + 2;

    typedef struct packed {
        logic        check_done;
        logic        pass;
        logic        timeout;
        logic        no_instr;
        logic [15:0] mismatch;
        logic [1:0]  row;
        logic [1:0]  col;
        logic [15:0] cycles;
        logic [15:0] instr;
    } result_t;

    logic          CLOCK_50;
    logic          rst_n;
    logic          done;
    logic [15:0]   clock_count;
    logic [15:0]   instr_cnt;
    logic          mem_rd_en;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_rd_data;
    logic          busy;
    logic          check_done;
    logic          pass;
    logic          timeout;
    logic          no_instr;
    logic [15:0]   mismatch_cnt;
    logic [1:0]    first_bad_row;
    logic [1:0]    first_bad_col;
    logic [15:0]   cycles_latched;
    logic [15:0]   instr_latched;

    logic [DW-1:0] mem [0:31];
    result_t       sb_q[$];
    int            checks;
    int            errors;

    matmul_self_check #(
        .M(M), .N(N), .N2(N2), .DW(DW), .TIMEOUT(5000), .AW(AW)
    ) dut (
        .CLOCK_50       (CLOCK_50),
        .rst_n          (rst_n),
        .done           (done),
        .clock_count    (clock_count),
        .instr_cnt      (instr_cnt),
        .mem_rd_en      (mem_rd_en),
        .mem_addr       (mem_addr),
        .mem_rd_data    (mem_rd_data),
        .busy           (busy),
        .check_done     (check_done),
        .pass           (pass),
        .timeout        (timeout),
        .no_instr       (no_instr),
        .mismatch_cnt   (mismatch_cnt),
        .first_bad_row  (first_bad_row),
        .first_bad_col  (first_bad_col),
        .cycles_latched (cycles_latched),
        .instr_latched  (instr_latched)
    );

    initial CLOCK_50 = 1'b0;
    always #5 CLOCK_50 = ~CLOCK_50;

    always @(posedge CLOCK_50) begin
        if (mem_rd_en) mem_rd_data <= mem[mem_addr];
    end

    function automatic result_t observe();
        result_t r;
        r.check_done = check_done;
        r.pass       = pass;
        r.timeout    = timeout;
        r.no_instr   = no_instr;
        r.mismatch   = mismatch_cnt;
        r.row        = first_bad_row;
        r.col        = first_bad_col;
        r.cycles     = cycles_latched;
        r.instr      = instr_latched;
        return r;
    endfunction

    function automatic logic [DW-1:0] model_elem(input int i, input int j);
        logic [DW-1:0] s;
        s = '0;
        for (int k = 0; k < N; k++) s = s + mem[i*N + k] * mem[BB + k*N2 + j];
        return s;
    endfunction

    function automatic result_t model_result(input bit to, input logic [15:0] cyc,
                                             input logic [15:0] ins);
        result_t r;
        int mm;
        r = '0;
        mm = 0;
        for (int i = 0; i < M; i++) begin
            for (int j = 0; j < N2; j++) begin
                if (model_elem(i, j) !== mem[BC + i*N2 + j]) begin
                    if (mm == 0) begin
                        r.row = 2'(i);
                        r.col = 2'(j);
                    end
                    mm++;
                end
            end
        end
        r.check_done = 1'b1;
        r.timeout    = to;
        r.no_instr   = (ins == 16'd0);
        r.mismatch   = 16'(mm);
        r.pass       = (mm == 0) && !to;
        r.cycles     = cyc;
        r.instr      = ins;
        return r;
    endfunction

    task automatic apply_reset();
        @(negedge CLOCK_50);
        rst_n = 1'b0;
        done = 1'b0;
        clock_count = 16'd0;
        instr_cnt = 16'd0;
        repeat (3) @(negedge CLOCK_50);
        rst_n = 1'b1;
    endtask

    task automatic load_default();
        for (int a = 0; a < 32; a++) mem[a] = '0;
        for (int a = 0; a < 8; a++) begin
            mem[a]      = 32'(a + 1);
            mem[BB + a] = 32'(a + 1);
        end
        mem[BC + 0] = 32'd50;
        mem[BC + 1] = 32'd60;
        mem[BC + 2] = 32'd114;
        mem[BC + 3] = 32'd140;
    endtask

    // Called at a negedge; the DUT samples the done edge at the next posedge.
    task automatic trigger_done();
        sb_q.push_back(model_result(1'b0, clock_count, instr_cnt));
        done = 1'b1;
    endtask

    // Counts posedges until check_done is seen at the following negedge.
    task automatic wait_check_done(input int limit, output int cyc, output bit ok);
        cyc = 0;
        ok = 1'b0;
        while (cyc < limit) begin
            @(posedge CLOCK_50);
            cyc++;
            @(negedge CLOCK_50);
            if (check_done) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        @(negedge CLOCK_50);
        rst_n = 1'b0;
        done = 1'b0;
        clock_count = 16'hAAAA;
        instr_cnt = 16'h5555;
        #1;
        checks++;
        if ({busy, mem_rd_en, mem_addr, observe()} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got busy=%b rd=%b addr=%0d res=%p want all zero",
                     busy, mem_rd_en, mem_addr, observe());
        end
        repeat (2) @(negedge CLOCK_50);
        rst_n = 1'b1;
        repeat (10) @(negedge CLOCK_50);
        checks++;
        if ({busy, mem_rd_en, check_done} !== 3'b000) begin
            errors++;
            $display("FAIL reset_idle got busy=%b rd=%b check_done=%b want 000",
                     busy, mem_rd_en, check_done);
        end
    endtask

    task automatic test_pass();
        result_t exp_r;
        int cyc;
        bit ok;
        apply_reset();
        load_default();
        instr_cnt = 16'd37;
        for (int c = 1; c < 100; c++) begin
            @(negedge CLOCK_50);
            clock_count = 16'(c);
        end
        @(negedge CLOCK_50);
        clock_count = 16'd100;
        trigger_done();
        @(posedge CLOCK_50);
        @(negedge CLOCK_50);
        clock_count = 16'd101;
        checks++;
        if ({busy, mem_rd_en, mem_addr} !== {1'b1, 1'b1, 5'd0}) begin
            errors++;
            $display("FAIL pass_first_read got busy=%b rd=%b addr=%0d want 1 1 0",
                     busy, mem_rd_en, mem_addr);
        end
        wait_check_done(200, cyc, ok);
        cyc = cyc + 1;
        checks++;
        if (!ok || cyc != LAT + 1) begin
            errors++;
            $display("FAIL pass_latency got %0d edges (seen=%b) want %0d", cyc - 1, ok, LAT);
        end
        exp_r = sb_q.pop_front();
        checks++;
        if (observe() !== exp_r || pass !== 1'b1) begin
            errors++;
            $display("FAIL pass_result got %p want %p", observe(), exp_r);
        end
    endtask

    task automatic test_mismatch();
        result_t exp_r;
        int cyc;
        bit ok;
        apply_reset();
        load_default();
        mem[BC + 1] = 32'd61;
        mem[BC + 3] = 32'd0;
        instr_cnt = 16'd90;
        clock_count = 16'd300;
        repeat (5) @(negedge CLOCK_50);
        trigger_done();
        wait_check_done(200, cyc, ok);
        checks++;
        if (!ok || cyc != LAT + 1) begin
            errors++;
            $display("FAIL mismatch_latency got %0d (seen=%b) want %0d", cyc - 1, ok, LAT);
        end
        exp_r = sb_q.pop_front();
        checks++;
        if (observe() !== exp_r || {pass, mismatch_cnt, first_bad_row, first_bad_col}
                                   !== {1'b0, 16'd2, 2'd0, 2'd1}) begin
            errors++;
            $display("FAIL mismatch_result got %p want %p", observe(), exp_r);
        end
    endtask

    task automatic test_signed();
        result_t exp_r;
        int cyc;
        bit ok;
        apply_reset();
        load_default();
        mem[0] = -32'sd3; mem[1] = '0; mem[2] = '0; mem[3] = '0;
        mem[BB + 0] = 32'd7; mem[BB + 2] = '0; mem[BB + 4] = '0; mem[BB + 6] = '0;
        for (int e = 1; e < 4; e++) mem[BC + e] = model_elem(e / N2, e % N2);
        mem[BC + 0] = 32'hFFFF_FFEB;
        instr_cnt = 16'd12;
        clock_count = 16'd77;
        repeat (3) @(negedge CLOCK_50);
        trigger_done();
        wait_check_done(200, cyc, ok);
        exp_r = sb_q.pop_front();
        checks++;
        if (!ok || observe() !== exp_r || pass !== 1'b1) begin
            errors++;
            $display("FAIL signed_result got %p want %p", observe(), exp_r);
        end
    endtask

    task automatic test_wrap();
        result_t exp_r;
        int cyc;
        bit ok;
        apply_reset();
        load_default();
        mem[0] = 32'h7FFF_FFFF; mem[1] = '0; mem[2] = '0; mem[3] = '0;
        mem[BB + 0] = 32'd2; mem[BB + 2] = '0; mem[BB + 4] = '0; mem[BB + 6] = '0;
        for (int e = 1; e < 4; e++) mem[BC + e] = model_elem(e / N2, e % N2);
        mem[BC + 0] = 32'hFFFF_FFFE;
        instr_cnt = 16'd13;
        clock_count = 16'd78;
        repeat (3) @(negedge CLOCK_50);
        trigger_done();
        wait_check_done(200, cyc, ok);
        exp_r = sb_q.pop_front();
        checks++;
        if (!ok || observe() !== exp_r || pass !== 1'b1) begin
            errors++;
            $display("FAIL wrap_result got %p want %p", observe(), exp_r);
        end
    endtask

    task automatic test_back_to_back();
        result_t exp_r;
        int cyc;
        bit ok;
        apply_reset();
        load_default();
        instr_cnt = 16'd0;
        clock_count = 16'h1234;
        repeat (2) @(negedge CLOCK_50);
        trigger_done();
        repeat (10) @(negedge CLOCK_50);
        clock_count = 16'hBEEF;
        instr_cnt = 16'd5;
        done = 1'b0;
        @(negedge CLOCK_50);
        done = 1'b1;
        wait_check_done(200, cyc, ok);
        cyc = cyc + 11;
        checks++;
        if (!ok || cyc != LAT + 1) begin
            errors++;
            $display("FAIL redone_latency got %0d (seen=%b) want %0d", cyc - 1, ok, LAT);
        end
        exp_r = sb_q.pop_front();
        checks++;
        if (observe() !== exp_r || no_instr !== 1'b1) begin
            errors++;
            $display("FAIL redone_result got %p want %p", observe(), exp_r);
        end
    endtask

    task automatic test_reset_mid();
        result_t exp_r;
        int cyc;
        bit ok;
        bit found;
        apply_reset();
        load_default();
        instr_cnt = 16'd44;
        clock_count = 16'd500;
        @(negedge CLOCK_50);
        trigger_done();
        void'(sb_q.pop_back());
        found = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge CLOCK_50);
            if (busy && !mem_rd_en) begin
                found = 1'b1;
                break;
            end
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (!found || {busy, mem_rd_en, mem_addr, observe()} !== '0) begin
            errors++;
            $display("FAIL midreset_outputs got busy=%b rd=%b res=%p reached_acc=%b want zero",
                     busy, mem_rd_en, observe(), found);
        end
        @(negedge CLOCK_50);
        done = 1'b0;
        @(negedge CLOCK_50);
        rst_n = 1'b1;
        repeat (20) @(negedge CLOCK_50);
        checks++;
        if ({busy, check_done} !== 2'b00) begin
            errors++;
            $display("FAIL midreset_no_restart got busy=%b check_done=%b want 00",
                     busy, check_done);
        end
        clock_count = 16'd600;
        trigger_done();
        wait_check_done(200, cyc, ok);
        checks++;
        if (!ok || cyc != LAT + 1) begin
            errors++;
            $display("FAIL midreset_latency got %0d (seen=%b) want %0d", cyc - 1, ok, LAT);
        end
        exp_r = sb_q.pop_front();
        checks++;
        if (observe() !== exp_r) begin
            errors++;
            $display("FAIL midreset_result got %p want %p", observe(), exp_r);
        end
    endtask

    task automatic test_timeout();
        result_t exp_r;
        int cyc;
        bit ok;
        apply_reset();
        load_default();
        instr_cnt = 16'd9;
        clock_count = 16'd4242;
        sb_q.push_back(model_result(1'b1, clock_count, instr_cnt));
        wait_check_done(6000, cyc, ok);
        checks++;
        if (!ok || cyc != 4999 + 1 + LAT) begin
            errors++;
            $display("FAIL timeout_latency got %0d (seen=%b) want %0d", cyc, ok, 4999 + 1 + LAT);
        end
        exp_r = sb_q.pop_front();
        checks++;
        if (observe() !== exp_r || {timeout, pass} !== 2'b10) begin
            errors++;
            $display("FAIL timeout_result got %p want %p", observe(), exp_r);
        end
    endtask

    task automatic test_timeout_edge();
        result_t exp_r;
        int cyc;
        bit ok;
        apply_reset();
        load_default();
        instr_cnt = 16'd21;
        clock_count = 16'd999;
        repeat (4999) @(posedge CLOCK_50);
        @(negedge CLOCK_50);
        trigger_done();
        wait_check_done(200, cyc, ok);
        checks++;
        if (!ok || cyc != LAT + 1) begin
            errors++;
            $display("FAIL tmo_edge_latency got %0d (seen=%b) want %0d", cyc - 1, ok, LAT);
        end
        exp_r = sb_q.pop_front();
        checks++;
        if (observe() !== exp_r || {timeout, pass} !== 2'b01) begin
            errors++;
            $display("FAIL tmo_edge_result got %p want %p", observe(), exp_r);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n = 1'b0;
        done = 1'b0;
        clock_count = 16'd0;
        instr_cnt = 16'd0;
        for (int a = 0; a < 32; a++) mem[a] = '0;
        test_reset();
        test_pass();
        test_mismatch();
        test_signed();
        test_wrap();
        test_back_to_back();
        test_reset_mid();
        test_timeout();
        test_timeout_edge();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
